aer_spike_encoder: RTL and testbench

Upstream stage of the axon router. It captures a parallel per-neuron spike vector from the neuron array and holds every spike in a pending register. It serializes the spikes into single-cycle address-event pulses, granted round-robin. Its `spike_out`/`source_id` outputs drive the axon interface's `spike_in`/`source_id` inputs directly, one event per cycle at most, with backpressure via `out_ready`.

---
 rtl/aer_spike_encoder_if.sv | 36 +++
 rtl/aer_spike_encoder.sv | 91 +++++++++
 tb/tb_aer_spike_encoder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aer_spike_encoder_if.sv
// rtl/aer_spike_encoder_if.sv - spike vector in, address-event out bundle for aer_spike_encoder
interface aer_spike_encoder_if #(
  parameter int ADDR_WIDTH    = 4,
  parameter int NUM_NEURONS   = 16,
  parameter int OVF_CNT_WIDTH = 8
);
  logic [NUM_NEURONS-1:0]   spike_vec;
  logic                     out_ready;
  logic                     spike_out;
  logic [ADDR_WIDTH-1:0]    source_id;
  logic                     busy;
  logic                     overflow;
  logic [OVF_CNT_WIDTH-1:0] ovf_count;

  // encoder side
  modport master (
    input  spike_vec,
    input  out_ready,
    output spike_out,
    output source_id,
    output busy,
    output overflow,
    output ovf_count
  );

  // neuron array / axon router side
  modport slave (
    output spike_vec,
    output out_ready,
    input  spike_out,
    input  source_id,
    input  busy,
    input  overflow,
    input  ovf_count
  );
endinterface

// File: rtl/aer_spike_encoder.sv
// rtl/aer_spike_encoder.sv - round-robin AER serializer of a parallel spike vector; AER_OVF_CNT_EN adds a saturating overflow counter
module aer_spike_encoder #(
  parameter int ADDR_WIDTH    = 4,
  parameter int NUM_NEURONS   = 16,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  aer_spike_encoder_if.master  bus
);

  logic [NUM_NEURONS-1:0] pending;
  logic [ADDR_WIDTH-1:0]  ptr;
  logic                   spike_out_q;
  logic [ADDR_WIDTH-1:0]  source_id_q;
  logic                   overflow_q;

  logic [NUM_NEURONS-1:0] req_hi;
  logic [NUM_NEURONS-1:0] search_vec;
  logic                   grant_valid;
  logic [ADDR_WIDTH-1:0]  grant_idx;
  logic [NUM_NEURONS-1:0] grant_onehot;
  logic [NUM_NEURONS-1:0] pending_next;
  logic                   ovf_hit;

  // Round-robin pick: lowest pending bit at or above ptr, else lowest pending bit overall.
  always_comb begin
    req_hi = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      req_hi[i] = pending[i] && (ADDR_WIDTH'(i) >= ptr);
    end
    search_vec  = (|req_hi) ? req_hi : pending;
    grant_valid = bus.out_ready && (|pending);
    grant_idx   = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (search_vec[i]) grant_idx = ADDR_WIDTH'(i);
    end
  end

  // Clear the granted bit, merge new arrivals and flag collisions on ungranted pending bits.
  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      grant_onehot[i] = grant_valid && (grant_idx == ADDR_WIDTH'(i));
    end
    pending_next = (pending & ~grant_onehot) | bus.spike_vec;
    ovf_hit      = |(bus.spike_vec & pending & ~grant_onehot);
  end

  // Pending register, pointer and registered event/overflow outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      ptr         <= '0;
      spike_out_q <= 1'b0;
      source_id_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pending     <= pending_next;
      spike_out_q <= grant_valid;
      overflow_q  <= ovf_hit;
      if (grant_valid) begin
        source_id_q <= grant_idx;
        ptr         <= (grant_idx == ADDR_WIDTH'(NUM_NEURONS - 1)) ? '0 : grant_idx + ADDR_WIDTH'(1);
      end
    end
  end

`ifdef AER_OVF_CNT_EN
  logic [OVF_CNT_WIDTH-1:0] ovf_count_q;

  // Saturating count of edges that raised overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count_q <= '0;
    end else if (ovf_hit && (ovf_count_q != {OVF_CNT_WIDTH{1'b1}})) begin
      ovf_count_q <= ovf_count_q + OVF_CNT_WIDTH'(1);
    end
  end

  assign bus.ovf_count = ovf_count_q;
`else
  assign bus.ovf_count = '0;
`endif

  assign bus.spike_out = spike_out_q;
  assign bus.source_id = source_id_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = |pending;

endmodule

// File: tb/tb_aer_spike_encoder.sv
// tb/tb_aer_spike_encoder.sv - self-checking bench for aer_spike_encoder
module tb_aer_spike_encoder;
  localparam int AW  = 4;
  localparam int NN  = 16;
  localparam int CW  = 8;
  localparam int CMAX = (1 << CW) - 1;
`ifdef AER_OVF_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic          clk;
  logic          rst;
  logic [NN-1:0] spike_vec;
  logic          out_ready;

  int tests;
  int fails;

  aer_spike_encoder_if #(.ADDR_WIDTH(AW), .NUM_NEURONS(NN), .OVF_CNT_WIDTH(CW)) bus ();

  assign bus.spike_vec = spike_vec;
  assign bus.out_ready = out_ready;

  aer_spike_encoder #(.ADDR_WIDTH(AW), .NUM_NEURONS(NN), .OVF_CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: pending set as a bit array, circular scan from ptr.
  logic [NN-1:0] m_p;
  int            m_ptr;
  logic          m_spike;
  int            m_id;
  logic          m_ovf;
  int            m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p     <= '0;
      m_ptr   <= 0;
      m_spike <= 1'b0;
      m_id    <= 0;
      m_ovf   <= 1'b0;
      m_cnt   <= 0;
    end else begin
      automatic int            g = -1;
      automatic logic [NN-1:0] np;
      automatic logic          any_ovf = 1'b0;
      if (out_ready) begin
        for (int k = 0; k < NN; k++) begin
          automatic int j = (m_ptr + k) % NN;
          if (g < 0 && m_p[j]) g = j;
        end
      end
      np = m_p;
      if (g >= 0) np[g] = 1'b0;
      for (int i = 0; i < NN; i++) begin
        if (spike_vec[i] && np[i]) any_ovf = 1'b1;
        np[i] = np[i] | spike_vec[i];
      end
      m_p     <= np;
      m_spike <= (g >= 0);
      if (g >= 0) begin
        m_id  <= g;
        m_ptr <= (g + 1) % NN;
      end
      m_ovf <= any_ovf;
      if (any_ovf && CNT_EN == 1 && m_cnt < CMAX) m_cnt <= m_cnt + 1;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_spike_out", int'(bus.spike_out), int'(m_spike));
      if (m_spike) check("cyc_source_id", int'(bus.source_id), m_id);
      check("cyc_busy", int'(bus.busy), int'(|m_p));
      check("cyc_overflow", int'(bus.overflow), int'(m_ovf));
      check("cyc_ovf_count", int'(bus.ovf_count), m_cnt);
    end
  end

  task automatic cycle(input logic [NN-1:0] v, input logic r);
    spike_vec = v;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_spike_out", int'(bus.spike_out), 0);
    check("rst_source_id", int'(bus.source_id), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_ovf_count", int'(bus.ovf_count), 0);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    spike_vec = '0;
    out_ready = 1'b0;
    @(negedge clk);
    check("init_spike_out", int'(bus.spike_out), 0);
    check("init_busy", int'(bus.busy), 0);
    check("init_ovf_count", int'(bus.ovf_count), 0);
    rst = 1'b0;

    // single spike on neuron 3
    cycle(16'h0008, 1'b1);
    check("single_busy1", int'(bus.busy), 1);
    check("single_nopulse", int'(bus.spike_out), 0);
    cycle(16'h0000, 1'b1);
    check("single_pulse", int'(bus.spike_out), 1);
    check("single_id", int'(bus.source_id), 3);
    check("model_single_id", m_id, 3);
    check("single_busy0", int'(bus.busy), 0);
    cycle(16'h0000, 1'b1);
    check("single_end", int'(bus.spike_out), 0);

    // three simultaneous spikes, ptr = 0
    do_reset();
    cycle(16'h8021, 1'b1);
    cycle(16'h0000, 1'b1);
    check("sim_id0", int'(bus.source_id), 0);
    cycle(16'h0000, 1'b1);
    check("sim_id5", int'(bus.source_id), 5);
    check("sim_pulse5", int'(bus.spike_out), 1);
    cycle(16'h0000, 1'b1);
    check("sim_id15", int'(bus.source_id), 15);
    check("sim_pulse15", int'(bus.spike_out), 1);
    check("model_ptr_wrap", m_ptr, 0);
    cycle(16'h8002, 1'b1);
    check("sim_idle", int'(bus.spike_out), 0);
    cycle(16'h0000, 1'b1);
    check("wrap_first_id1", int'(bus.source_id), 1);
    cycle(16'h0000, 1'b1);
    check("wrap_then_id15", int'(bus.source_id), 15);

    // fairness from ptr = 6
    cycle(16'h0020, 1'b1);
    cycle(16'h0000, 1'b1);
    check("rr_setup_id5", int'(bus.source_id), 5);
    cycle(16'h0204, 1'b1);
    cycle(16'h0000, 1'b1);
    check("rr_first_9", int'(bus.source_id), 9);
    cycle(16'h0000, 1'b1);
    check("rr_second_2", int'(bus.source_id), 2);

    // backpressure with bits 1 and 4 pending
    do_reset();
    cycle(16'h0012, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(16'h0000, 1'b0);
      check("bp_no_pulse", int'(bus.spike_out), 0);
      check("bp_busy", int'(bus.busy), 1);
    end
    cycle(16'h0000, 1'b1);
    check("bp_id1", int'(bus.source_id), 1);
    cycle(16'h0000, 1'b1);
    check("bp_id4", int'(bus.source_id), 4);
    check("bp_pulse4", int'(bus.spike_out), 1);
    cycle(16'h0000, 1'b1);
    check("bp_drained", int'(bus.busy), 0);

    // grant and re-arrival on the same bit is not an overflow
    do_reset();
    cycle(16'h0004, 1'b0);
    cycle(16'h0004, 1'b1);
    check("rearm_id2", int'(bus.source_id), 2);
    check("rearm_no_ovf", int'(bus.overflow), 0);
    check("rearm_busy", int'(bus.busy), 1);
    cycle(16'h0000, 1'b1);
    check("rearm_again_id2", int'(bus.source_id), 2);
    check("rearm_again_pulse", int'(bus.spike_out), 1);

    // overflow on bit 7
    do_reset();
    cycle(16'h0080, 1'b0);
    cycle(16'h0080, 1'b0);
    check("ovf_pulse", int'(bus.overflow), 1);
    check("ovf_count1", int'(bus.ovf_count), CNT_EN);
    cycle(16'h0000, 1'b0);
    check("ovf_one_cycle", int'(bus.overflow), 0);
    cycle(16'h0000, 1'b1);
    check("ovf_id7", int'(bus.source_id), 7);
    check("ovf_pulse7", int'(bus.spike_out), 1);
    cycle(16'h0000, 1'b1);
    check("ovf_single_event", int'(bus.spike_out), 0);
    check("ovf_drained", int'(bus.busy), 0);

    // 260 collisions saturate the counter
    do_reset();
    cycle(16'h0001, 1'b0);
    repeat (260) cycle(16'h0001, 1'b0);
    check("sat_count", int'(bus.ovf_count), CNT_EN * 255);
    check("sat_overflow", int'(bus.overflow), 1);
    cycle(16'h0000, 1'b1);
    check("sat_release_id0", int'(bus.source_id), 0);
    cycle(16'h0000, 1'b1);
    check("sat_hold", int'(bus.ovf_count), CNT_EN * 255);

    // reset mid-operation with events pending
    do_reset();
    cycle(16'h01F0, 1'b0);
    cycle(16'h0000, 1'b1);
    check("mid_pulse", int'(bus.spike_out), 1);
    check("mid_id4", int'(bus.source_id), 4);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(16'h0000, 1'b1);
      check("mid_no_stale", int'(bus.spike_out), 0);
    end
    cycle(16'h8001, 1'b1);
    cycle(16'h0000, 1'b1);
    check("mid_ptr0_id0", int'(bus.source_id), 0);
    cycle(16'h0000, 1'b1);
    check("mid_ptr0_id15", int'(bus.source_id), 15);
    cycle(16'h0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
